// File: rtl/program_loader.sv
// Streams 24-bit command words into program RAM as three bytes, MSB first, holding the core in reset meanwhile.
// Optional LOADER_CHECKSUM_EN adds a running byte checksum; without it checksum is tied to zero.
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*DATA_W-1:0]   in_word,
    input  logic                  in_last,
    output logic                  write_en,
    output logic [ADDR_W-1:0]     write_adress,
    output logic [DATA_W-1:0]     data_in,
    output logic                  hold_cpu,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_W-1:0]     words_written,
    output logic [DATA_W-1:0]     checksum
);

    localparam int WORD_W = 3 * DATA_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_WR0    = 3'd2;
    localparam logic [2:0] S_WR1    = 3'd3;
    localparam logic [2:0] S_WR2    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [ADDR_W+1:0] SPACE      = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W+1:0] WORD_BYTES = {{ADDR_W{1'b0}}, 2'b11};
    localparam logic [ADDR_W:0]   PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    // One extra bit lets the pointer reach 2^ADDR_W after the final address is written.
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] words_written_q, words_written_d;
    logic              overflow_q, overflow_d;

    logic [ADDR_W+1:0] room_left;
    logic              has_room;

    assign room_left = SPACE - {1'b0, ptr_q};
    assign has_room  = (room_left >= WORD_BYTES);

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        word_d          = word_q;
        last_d          = last_q;
        words_written_d = words_written_q;
        overflow_d      = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d           = {1'b0, base_addr};
                    words_written_d = '0;
                    overflow_d      = 1'b0;
                    state_d         = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (in_valid) begin
                    if (has_room) begin
                        word_d  = in_word;
                        last_d  = in_last;
                        state_d = S_WR0;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_WR0: begin
                ptr_d   = ptr_q + PTR_ONE;
                state_d = S_WR1;
            end
            S_WR1: begin
                ptr_d   = ptr_q + PTR_ONE;
                state_d = S_WR2;
            end
            S_WR2: begin
                ptr_d           = ptr_q + PTR_ONE;
                words_written_d = words_written_q + CNT_ONE;
                state_d         = last_q ? S_DONE : S_ACCEPT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        write_en = 1'b0;
        data_in  = '0;
        case (state_q)
            S_WR0: begin
                write_en = 1'b1;
                data_in  = word_q[WORD_W-1 -: DATA_W];
            end
            S_WR1: begin
                write_en = 1'b1;
                data_in  = word_q[2*DATA_W-1 -: DATA_W];
            end
            S_WR2: begin
                write_en = 1'b1;
                data_in  = word_q[DATA_W-1:0];
            end
            default: begin
                write_en = 1'b0;
                data_in  = '0;
            end
        endcase
    end

    assign in_ready      = (state_q == S_ACCEPT) && has_room;
    assign write_adress  = ptr_q[ADDR_W-1:0];
    assign busy          = (state_q != S_IDLE);
    assign hold_cpu      = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign overflow      = overflow_q;
    assign words_written = words_written_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            word_q          <= '0;
            last_q          <= 1'b0;
            words_written_q <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            word_q          <= word_d;
            last_q          <= last_d;
            words_written_q <= words_written_d;
            overflow_q      <= overflow_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && start) begin
            checksum_d = '0;
        end else if (write_en) begin
            checksum_d = checksum_q + data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader; a session-level model predicts every RAM byte, counts and flags.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_word;
    logic        in_last;
    logic        write_en;
    logic [7:0]  write_adress;
    logic [7:0]  data_in;
    logic        hold_cpu;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  words_written;
    logic [7:0]  checksum;

    program_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
        .write_en(write_en), .write_adress(write_adress), .data_in(data_in),
        .hold_cpu(hold_cpu), .busy(busy), .done(done), .overflow(overflow),
        .words_written(words_written), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected RAM writes as {address, byte}, in order.
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {16'h0, write_adress, data_in}, 32'hFFFF_FFFF);
            end else begin
                check("wr_addr_data", {16'h0, write_adress, data_in}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    logic [23:0] sess_words[8];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_write_en"}, write_en, 0);
        check({tag, "_addr"}, write_adress, 0);
        check({tag, "_data"}, data_in, 0);
        check({tag, "_hold"}, hold_cpu, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_ww"}, words_written, 0);
        check({tag, "_cks"}, checksum, 0);
    endtask

    // One session: a word is accepted only if it fits entirely below 2^8; the first word that does not fit ends it.
    task automatic run_session(input logic [7:0] base, input int nw, input int gap_lo, input int gap_hi,
                               input bit hold_valid, input bit stray_start);
        int          ptr;
        int          written;
        logic [7:0]  cks;
        bit          room;
        bit          ovf;
        logic [23:0] w;
        logic [7:0]  b;
        int          g;
        @(negedge clk);
        start = 1'b1; base_addr = base;
        @(negedge clk);
        start = 1'b0; base_addr = 8'($urandom);
        check("hold_after_start", hold_cpu, 1);
        check("busy_after_start", busy, 1);
        check("ovf_cleared", overflow, 0);
        check("ww_cleared", words_written, 0);
        check("cks_cleared", checksum, 0);
        ptr = base; written = 0; cks = 8'h0; ovf = 1'b0;
        for (int i = 0; i < nw && !ovf; i++) begin
            room = ((256 - ptr) >= 3);
            if (!hold_valid && i > 0) begin
                in_valid = 1'b0;
                g = $urandom_range(gap_hi, gap_lo);
                repeat (g) begin
                    check("rdy_wait", in_ready, room);
                    check("we_gap", write_en, 0);
                    @(negedge clk);
                end
            end
            w = sess_words[i];
            in_valid = 1'b1; in_word = w; in_last = (i == nw - 1);
            check("rdy_offer", in_ready, room);
            if (room) begin
                for (int k = 0; k < 3; k++) begin
                    b = w[23 - 8*k -: 8];
                    exp_q.push_back({8'(ptr + k), b});
                    cks = cks + b;
                end
            end
            @(negedge clk);
            if (!room) begin
                in_valid = 1'b0;
                ovf = 1'b1;
                check("ovf_set", overflow, 1);
                check("ovf_busy", busy, 0);
                check("ovf_hold", hold_cpu, 0);
                check("ovf_no_done", done, 0);
            end else begin
                ptr = ptr + 3;
                written++;
                in_valid = hold_valid && (i + 1 < nw);
                if (in_valid) begin
                    in_word = sess_words[i+1];
                    in_last = (i + 1 == nw - 1);
                end
                if (stray_start && i == 0) begin
                    start = 1'b1; base_addr = 8'h80;
                end
                repeat (3) begin
                    check("rdy_writing", in_ready, 0);
                    check("we_writing", write_en, 1);
                    @(negedge clk);
                    start = 1'b0;
                end
                if (i == nw - 1) begin
                    check("done_pulse", done, 1);
                    check("hold_in_done", hold_cpu, 1);
                    @(negedge clk);
                    check("done_cleared", done, 0);
                    check("busy_fall", busy, 0);
                    check("hold_fall", hold_cpu, 0);
                end else begin
                    check("no_early_done", done, 0);
                end
            end
        end
        in_valid = 1'b0;
        check("words_written", words_written, written);
`ifdef LOADER_CHECKSUM_EN
        check("checksum", checksum, cks);
`else
        check("checksum", checksum, 0);
`endif
        check("ovf_final", overflow, ovf);
    endtask

    task automatic run_reset_midwrite();
        logic [23:0] w;
        w = 24'($urandom);
        @(negedge clk);
        start = 1'b1; base_addr = 8'h40;
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b1; in_word = w; in_last = 1'b0;
        exp_q.push_back({8'h40, w[23:16]});
        exp_q.push_back({8'h41, w[15:8]});
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("wr1_active", write_en, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        check("midrst_queue", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 8'h0;
        in_valid = 1'b0; in_word = 24'h0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        sess_words[0] = 24'hA1B2C3;
        run_session(8'h10, 1, 0, 0, 1'b0, 1'b0);

        sess_words[0] = 24'h000001; sess_words[1] = 24'h000002; sess_words[2] = 24'h000003;
        run_session(8'h00, 3, 0, 0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) sess_words[i] = 24'($urandom);
        run_session(8'h20, 3, 5, 5, 1'b0, 1'b0);

        sess_words[0] = 24'h112233; sess_words[1] = 24'($urandom);
        run_session(8'hFD, 2, 0, 2, 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) sess_words[i] = 24'($urandom);
        run_session(8'h30, 2, 0, 0, 1'b0, 1'b1);

        run_reset_midwrite();

        for (int s = 0; s < 24; s++) begin
            logic [7:0] base;
            int nw;
            base = ($urandom_range(1, 0) == 1) ? 8'($urandom_range(255, 240)) : 8'($urandom);
            nw = $urandom_range(5, 1);
            for (int i = 0; i < nw; i++) sess_words[i] = 24'($urandom);
            run_session(base, nw, 0, 3, 1'($urandom_range(1, 0)), 1'b0);
        end

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
